// File: rtl/bcm_scan_ctrl.sv
// Binary-code-modulation scan controller for HUB75-style LED panels: shifts one row
// per bit plane, latches it, then lights it for BASE_TIME<<plane cycles.
// Optional post-latch blanking guard is enabled by defining BCM_BLANK_GUARD_EN.
module bcm_scan_ctrl #(
  parameter int COLS      = 64,
  parameter int ROW_BITS  = 4,
  parameter int BASE_TIME = 8,
  parameter int GUARD     = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  output logic [ROW_BITS+$clog2(COLS)-1:0] pix_addr,
  input  logic [5:0]                       rgb_in,
  output logic [1:0]                       plane,
  output logic [5:0]                       rgb_out,
  output logic                             sclk,
  output logic                             latch,
  output logic                             oe_n,
  output logic [ROW_BITS-1:0]              row_addr,
  output logic                             frame_done
);

  localparam int CB    = $clog2(COLS);
  // One counter serves both the display window and the guard interval.
  localparam int CNT_W = $clog2((BASE_TIME << 3) + GUARD + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SHIFT   = 3'd1;
  localparam logic [2:0] S_LATCH   = 3'd2;
`ifdef BCM_BLANK_GUARD_EN
  localparam logic [2:0] S_GUARD   = 3'd3;
`endif
  localparam logic [2:0] S_DISPLAY = 3'd4;

  localparam logic [1:0] P0 = 2'd0;
  localparam logic [1:0] P1 = 2'd1;
  localparam logic [1:0] P2 = 2'd2;

  logic [2:0]          state_q, state_d;
  logic [1:0]          phase_q, phase_d;
  logic [CB-1:0]       col_q, col_d;
  logic [1:0]          plane_q, plane_d;
  logic [ROW_BITS-1:0] row_q, row_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    disp_last;
  logic [5:0]          rgb_q, rgb_d;
  logic                sclk_q, sclk_d;
  logic                latch_q, latch_d;
  logic                oe_n_q, oe_n_d;
  logic                fd_q, fd_d;
  logic [ROW_BITS-1:0] row_addr_q, row_addr_d;

  always_comb begin
    disp_last = CNT_W'((BASE_TIME << plane_q) - 1);

    state_d = state_q;
    phase_d = phase_q;
    col_d   = col_q;
    plane_d = plane_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    fd_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (en) begin
          state_d = S_SHIFT;
          phase_d = P0;
          col_d   = '0;
        end
      end
      S_SHIFT: begin
        if (phase_q == P2) begin
          phase_d = P0;
          if (col_q == CB'(COLS - 1)) begin
            col_d   = '0;
            state_d = S_LATCH;
          end else begin
            col_d = col_q + 1'b1;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      S_LATCH: begin
        cnt_d = '0;
`ifdef BCM_BLANK_GUARD_EN
        state_d = S_GUARD;
`else
        state_d = S_DISPLAY;
`endif
      end
`ifdef BCM_BLANK_GUARD_EN
      S_GUARD: begin
        if (cnt_q == CNT_W'(GUARD - 1)) begin
          cnt_d   = '0;
          state_d = S_DISPLAY;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      S_DISPLAY: begin
        if (cnt_q == disp_last) begin
          cnt_d = '0;
          if (plane_q != 2'd3) begin
            plane_d = plane_q + 1'b1;
            state_d = S_SHIFT;
          end else begin
            // en is only honoured here, once the whole row has been shown.
            plane_d = '0;
            row_d   = row_q + 1'b1;
            fd_d    = &row_q;
            state_d = en ? S_SHIFT : S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Panel strobes are decoded from the next state so they line up with it once registered.
    sclk_d     = (state_d == S_SHIFT) && (phase_d == P2);
    latch_d    = (state_d == S_LATCH);
    oe_n_d     = (state_d != S_DISPLAY);
    row_addr_d = (state_d == S_LATCH) ? row_d : row_addr_q;
    rgb_d      = ((state_q == S_SHIFT) && (phase_q == P1)) ? rgb_in : rgb_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      phase_q    <= P0;
      col_q      <= '0;
      plane_q    <= '0;
      row_q      <= '0;
      cnt_q      <= '0;
      rgb_q      <= '0;
      sclk_q     <= 1'b0;
      latch_q    <= 1'b0;
      oe_n_q     <= 1'b1;
      fd_q       <= 1'b0;
      row_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      col_q      <= col_d;
      plane_q    <= plane_d;
      row_q      <= row_d;
      cnt_q      <= cnt_d;
      rgb_q      <= rgb_d;
      sclk_q     <= sclk_d;
      latch_q    <= latch_d;
      oe_n_q     <= oe_n_d;
      fd_q       <= fd_d;
      row_addr_q <= row_addr_d;
    end
  end

  assign pix_addr   = {row_q, col_q};
  assign plane      = plane_q;
  assign rgb_out    = rgb_q;
  assign sclk       = sclk_q;
  assign latch      = latch_q;
  assign oe_n       = oe_n_q;
  assign row_addr   = row_addr_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_bcm_scan_ctrl.sv
// Bench for bcm_scan_ctrl: directed reset checks, then a random row sequence checked
// by an event scoreboard fed from a row-level reference model.
module tb_bcm_scan_ctrl;

  localparam int COLS      = 4;
  localparam int ROW_BITS  = 1;
  localparam int BASE_TIME = 2;
  localparam int GUARD     = 2;
  localparam int CB        = 2;
  localparam int ROWS      = 1 << ROW_BITS;
`ifdef BCM_BLANK_GUARD_EN
  localparam int GAP = GUARD;
`else
  localparam int GAP = 0;
`endif

  logic                   clk;
  logic                   rst;
  logic                   en;
  logic [ROW_BITS+CB-1:0] pix_addr;
  logic [5:0]             rgb_in;
  logic [1:0]             plane;
  logic [5:0]             rgb_out;
  logic                   sclk;
  logic                   latch;
  logic                   oe_n;
  logic [ROW_BITS-1:0]    row_addr;
  logic                   frame_done;

  bcm_scan_ctrl #(
    .COLS(COLS), .ROW_BITS(ROW_BITS), .BASE_TIME(BASE_TIME), .GUARD(GUARD)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .pix_addr(pix_addr), .rgb_in(rgb_in),
    .plane(plane), .rgb_out(rgb_out), .sclk(sclk), .latch(latch), .oe_n(oe_n),
    .row_addr(row_addr), .frame_done(frame_done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // bit-plane frame memory with one cycle read latency
  logic [5:0] mem [0:3][0:ROWS*COLS-1];
  initial begin
    rgb_in = '0;
    for (int p = 0; p < 4; p++)
      for (int a = 0; a < ROWS * COLS; a++)
        mem[p][a] = 6'($urandom);
    mem[0][2] = 6'h2A;
  end
  always @(posedge clk) rgb_in <= mem[plane][pix_addr];

  // scoreboard
  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_q[$];
  bit mon_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic sb_check(input string name, input logic [15:0] act);
    logic [15:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s actual=%0h required=none (queue empty)", name, act);
    end else begin
      e = exp_q.pop_front();
      chk(name, 32'(act), 32'(e));
    end
  endtask

  // Reference: what a complete row scan must look like on the panel pins.
  task automatic model_row(input int r);
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < COLS; c++)
        exp_q.push_back({2'd0, 2'(p), 6'd0, mem[p][r*COLS+c]});
      exp_q.push_back({2'd1, 2'(p), 4'(r), 8'(3*COLS-2)});
      exp_q.push_back({2'd2, 2'(p), 4'(GAP), 8'(BASE_TIME << p)});
    end
    if (r == ROWS - 1) exp_q.push_back(16'hC000);
  endtask

  // monitor
  int cyc, rise_cyc, gap, disp;
  bit seen_first, in_gap, prev_sclk, prev_oe_n;
  logic [1:0] disp_plane;
  logic [ROW_BITS-1:0] prev_row_addr;

  always @(negedge clk) begin
    if (!mon_en) begin
      cyc = 0; rise_cyc = 0; gap = 0; disp = 0;
      seen_first = 0; in_gap = 0; prev_sclk = 0; prev_oe_n = 1;
      disp_plane = '0; prev_row_addr = row_addr;
    end else begin
      cyc++;
      if (sclk && !prev_sclk) begin
        if (!seen_first) begin
          seen_first = 1;
          rise_cyc = cyc;
        end
        sb_check("col_data", {2'd0, plane, 6'd0, rgb_out});
      end
      if (latch) begin
        chk("latch_oe_n", 32'(oe_n), 32'd1);
        chk("latch_sclk", 32'(sclk), 32'd0);
        sb_check("latch", {2'd1, plane, 4'(row_addr), 8'(cyc - rise_cyc)});
        seen_first = 0;
        in_gap = 1;
        gap = 0;
      end else if (in_gap && oe_n) begin
        gap++;
      end
      if (!oe_n) begin
        if (prev_oe_n) begin
          disp = 0;
          in_gap = 0;
          disp_plane = plane;
        end
        disp++;
      end
      if (oe_n && !prev_oe_n) sb_check("display", {2'd2, disp_plane, 4'(gap), 8'(disp)});
      if (frame_done) sb_check("frame_done", 16'hC000);
      if (row_addr != prev_row_addr) chk("row_addr_blank", 32'(oe_n), 32'd1);
      prev_sclk = sclk;
      prev_oe_n = oe_n;
      prev_row_addr = row_addr;
    end
  end

  // driver tasks
  task automatic wait_latch(input int p);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(latch && plane == 2'(p)) && n < 2000);
    if (!(latch && plane == 2'(p))) begin
      checks++;
      failures++;
      $display("FAIL wait_latch_p%0d actual=timeout required=latch", p);
    end
  endtask

  task automatic wait_oe(input logic v);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (oe_n !== v && n < 2000);
    if (oe_n !== v) begin
      checks++;
      failures++;
      $display("FAIL wait_oe actual=timeout required=oe_n_%0d", v);
    end
  endtask

  // stimulus
  initial begin
    int row;
    int dp;
    bit stay;
    bit idle;
    int n;

    rst = 1'b1;
    en  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pix_addr", 32'(pix_addr), 32'd0);
    chk("rst_rgb_out", 32'(rgb_out), 32'd0);
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_latch", 32'(latch), 32'd0);
    chk("rst_oe_n", 32'(oe_n), 32'd1);
    chk("rst_row_addr", 32'(row_addr), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_plane", 32'(plane), 32'd0);

    en = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_over_en_oe_n", 32'(oe_n), 32'd1);
    chk("rst_over_en_sclk", 32'(sclk), 32'd0);

    rst = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(plane == 2'd2 && !oe_n) && n < 2000);
    chk("reach_plane2_display", 32'(plane == 2'd2 && !oe_n), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_oe_n", 32'(oe_n), 32'd1);
    chk("midrst_plane", 32'(plane), 32'd0);
    chk("midrst_row_addr", 32'(row_addr), 32'd0);
    chk("midrst_latch", 32'(latch), 32'd0);
    chk("midrst_rgb_out", 32'(rgb_out), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("restart_pix_addr", 32'(pix_addr), 32'd0);
    chk("restart_sclk_p0", 32'(sclk), 32'd0);
    repeat (2) @(negedge clk);
    chk("restart_sclk_p2", 32'(sclk), 32'd1);

    en  = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    mon_en = 1;

    row  = 0;
    idle = 1;
    for (int k = 0; k < 6; k++) begin
      model_row(row);
      if (idle) en = 1'b1;
      if (k == 0) begin
        dp = 1;
        stay = 0;
      end else if (k == 1) begin
        dp = $urandom_range(0, 3);
        stay = 1;
      end else if (k == 5) begin
        dp = $urandom_range(0, 3);
        stay = 0;
      end else begin
        dp = $urandom_range(0, 3);
        stay = 1'($urandom_range(0, 1));
      end
      wait_latch(dp);
      en = stay;
      if (dp != 3) wait_latch(3);
      wait_oe(1'b0);
      wait_oe(1'b1);
      row = (row + 1) % ROWS;
      idle = !stay;
      if (!stay) begin
        repeat ($urandom_range(2, 6)) @(negedge clk);
        chk("idle_oe_n", 32'(oe_n), 32'd1);
        chk("idle_sclk", 32'(sclk), 32'd0);
        chk("idle_pix_addr", 32'(pix_addr), 32'(row * COLS));
        chk("idle_plane", 32'(plane), 32'd0);
      end
    end

    repeat (5) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    mon_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcm_scan_ctrl.md
BCM_SCAN_CTRL -- requirements
Module: bcm_scan_ctrl

Interface
REQ-001 SHALL have parameter COLS, default 64, meaning columns shifted per row (power of two, at least 2); CB = log2(COLS).
REQ-002 SHALL have parameter ROW_BITS, default 4, meaning row-pair address width (2**ROW_BITS scanned row pairs).
REQ-003 SHALL have parameter BASE_TIME, default 8, meaning display cycles for bit plane 0.
REQ-004 SHALL have parameter GUARD, default 2, meaning blanking cycles after latch (used only with the REQ-021 macro).
REQ-005 SHALL have ports, in order:
- clk  in  1  sole clock.
- rst  in  1  reset; synchronous, active-high.
- en  in  1  scan enable.
- pix_addr  out  ROW_BITS+CB  frame-memory read address {row, col}.
- rgb_in  in  6  bit-plane pixel bits {R0,G0,B0,R1,G1,B1} from the bit-plane multiplexer.
- plane  out  2  bit-plane select driving the multiplexer select.
- rgb_out  out  6  panel data lines.
- sclk  out  1  panel shift clock.
- latch  out  1  panel latch strobe.
- oe_n  out  1  panel output enable, active-low.
- row_addr  out  ROW_BITS  panel row address.
- frame_done  out  1  one-cycle pulse at end of frame.

Function
REQ-006 SHALL implement FSM states IDLE, SHIFT, LATCH, GUARD (macro only) and DISPLAY.
REQ-007 SHALL, in IDLE with oe_n=1, go to SHIFT when en=1, else stay in IDLE.
REQ-008 SHALL spend exactly 3 cycles per column in SHIFT, in phases P0, P1 and P2.
- P0: pix_addr={row,col}, sclk=0.
- P1: sclk=0; rgb_in is valid (1-cycle memory latency); rgb_out registers rgb_in at the end of P1.
- P2: sclk=1.
REQ-009 SHALL make SHIFT last exactly 3*COLS cycles; col increments after each P2 and wraps from COLS-1 to 0 on leaving SHIFT.
REQ-010 SHALL hold plane constant for the whole SHIFT, LATCH, GUARD and DISPLAY sequence of one plane.
REQ-011 SHALL assert latch=1 for exactly one cycle in LATCH, with oe_n=1 and sclk=0.
REQ-012 SHALL load row_addr with the current row in LATCH and hold it otherwise, so it changes only while oe_n=1.
REQ-013 SHALL drive oe_n=0 in DISPLAY for exactly BASE_TIME<<plane cycles, and oe_n=1 in all other states.
REQ-014 SHALL, at the end of DISPLAY:
- plane<3: increment plane and go to SHIFT.
- plane=3: set plane=0 and increment row.
REQ-015 SHALL, after plane 3, wrap row from 2**ROW_BITS-1 to 0 and pulse frame_done=1 for that one cycle.
REQ-016 SHALL, after plane 3, go to SHIFT if en=1, else to IDLE.
REQ-017 SHALL ignore en outside IDLE and the end of plane 3; deasserting en mid-row completes the row's remaining planes.
REQ-018 SHALL register all outputs; no combinational path from any input to any output.

Reset
REQ-019 SHALL, with rst=1 at a clock edge, regardless of state (including mid-SHIFT or mid-DISPLAY):
- go to IDLE with plane=0, row=0, col=0.
- drive pix_addr=0, rgb_out=0, sclk=0, latch=0, oe_n=1, row_addr=0, frame_done=0.
REQ-020 SHALL give rst priority over en.

Configuration
REQ-021 SHALL, with macro BCM_BLANK_GUARD_EN defined, insert state GUARD between LATCH and DISPLAY for exactly GUARD cycles with oe_n=1 and latch=0, to suppress ghosting.
REQ-022 SHALL, with BCM_BLANK_GUARD_EN undefined, go from LATCH directly to DISPLAY; no GUARD state or counter exists and the GUARD parameter is unused.

Verification (bench uses COLS=4, ROW_BITS=1, BASE_TIME=2, GUARD=2)
REQ-023 Reset mid-DISPLAY of plane 2 -> next cycle oe_n=1, plane=0, row_addr=0, latch=0, rgb_out=0; with en=1 the first SHIFT starts with pix_addr=0.
REQ-024 Memory model returns rgb_in=6'h2A one cycle after address {0,2} -> rgb_out=6'h2A while sclk=1 for column 2; exactly 4 sclk rising edges per SHIFT.
REQ-025 Guard disabled, one row -> per plane 12 SHIFT cycles, 1 latch cycle, then oe_n=0 for 2, 4, 8 and 16 cycles for planes 0-3.
REQ-026 Guard enabled -> 2 cycles with oe_n=1 and latch=0 between every latch pulse and DISPLAY; DISPLAY lengths unchanged.
REQ-027 en=1 for a full frame -> row_addr goes 0 then 1; after plane 3 of row 1 frame_done pulses once and row wraps to 0.
REQ-028 en dropped during plane 1 of row 0 -> planes 2 and 3 complete, then IDLE with oe_n=1 and row=1; en=1 again resumes at plane 0 of row 1.
